// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider: one quotient bit per cycle, signed or unsigned,
// valid/ready in and out, result held in DONE until the consumer takes it.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens at a rising edge where valid & ready are both 1;
  // in_ready = (state==IDLE) and out_valid = (state==DONE), neither depends on the other side.
  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   prem;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] dvsr;
  logic             q_neg, r_neg, sgn, dbz_pend;
  logic             accept, divisor_zero;
  logic [WIDTH-1:0] dividend_abs, divisor_abs;
  logic [WIDTH+1:0] diff;

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign dbg_state    = state;
  assign accept       = in_valid & in_ready & ~flush;
  assign divisor_zero = (divisor == '0);

  assign dividend_abs = (in_signed & dividend[WIDTH-1]) ? ({WIDTH{1'b0}} - dividend) : dividend;
  assign divisor_abs  = (in_signed & divisor[WIDTH-1])  ? ({WIDTH{1'b0}} - divisor)  : divisor;

  // Trial subtraction of the shifted partial remainder; the top bit is the borrow.
  assign diff = {prem, work[WIDTH-1]} - {2'b00, dvsr};

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept) state_d = divisor_zero ? FIX : BUSY;
      BUSY: if (cnt == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      prem        <= '0;
      work        <= '0;
      dvsr        <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      sgn         <= 1'b0;
      dbz_pend    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: if (accept) begin
          // A zero divisor skips BUSY; work then carries the raw dividend as the remainder.
          work     <= divisor_zero ? dividend : dividend_abs;
          dvsr     <= divisor_abs;
          prem     <= '0;
          cnt      <= CW'(WIDTH - 1);
          q_neg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
          r_neg    <= dividend[WIDTH-1];
          sgn      <= in_signed;
          dbz_pend <= divisor_zero;
        end
        BUSY: begin
          if (diff[WIDTH+1]) begin
            prem <= {prem[WIDTH-1:0], work[WIDTH-1]};
            work <= {work[WIDTH-2:0], 1'b0};
          end else begin
            prem <= diff[WIDTH:0];
            work <= {work[WIDTH-2:0], 1'b1};
          end
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FIX: begin
          if (dbz_pend) begin
            quotient    <= '1;
            remainder   <= work;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= (sgn & q_neg) ? -work : work;
            remainder   <= (sgn & r_neg) ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32): hand-computed vectors, latency, backpressure,
// flush and mid-operation reset, checked through immediate assertions and an expected queue.
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_signed = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         in_ready, out_valid, div_by_zero;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad = 0;
  logic [2*W:0] exp_q[$];

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: present operands at a negedge, accept edge T0 follows; returns at T0+1ns.
  task automatic start(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid  = 1'b1;
    in_signed = s;
    dividend  = a;
    divisor   = b;
    chk("in_ready_idle", W'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Counts edges after T0 until out_valid, then checks against the scoreboard head.
  task automatic wait_result(input string tag, input int exp_lat);
    int n;
    logic [2*W:0] e;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
    chk({tag, "_latency"}, W'(n), W'(exp_lat));
    e = exp_q.pop_front();
    chk({tag, "_quotient"}, quotient, e[2*W-1:W]);
    chk({tag, "_remainder"}, remainder, e[W-1:0]);
    chk({tag, "_dbz"}, W'(div_by_zero), W'(e[2*W]));
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_idle_in_ready"}, W'(in_ready), 1);
    chk({tag, "_idle_out_valid"}, W'(out_valid), 0);
  endtask

  task automatic op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] eq, input logic [W-1:0] er, input logic ed, input int lat);
    exp_q.push_back({ed, eq, er});
    start(s, a, b);
    wait_result(tag, lat);
    release_result(tag);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      seen = seen | out_valid;
    end
    chk(tag, W'(seen), 0);
  endtask

  initial begin
    #1;
    chk("rst_in_ready", W'(in_ready), 1);
    chk("rst_out_valid", W'(out_valid), 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", W'(div_by_zero), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    op("u100_7",  1'b0, 32'd100,      32'd7,          32'd14,         32'd2,          1'b0, 33);
    op("s-7_2",   1'b1, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33);
    op("u-7_2",   1'b0, 32'hFFFFFFF9, 32'd2,          32'h7FFFFFFC,   32'd1,          1'b0, 33);
    op("s7_-2",   1'b1, 32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 33);
    op("s5_0",    1'b1, 32'd5,        32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 1);
    op("u0_0",    1'b0, 32'd0,        32'd0,          32'hFFFFFFFF,   32'd0,          1'b1, 1);
    op("s_ovf",   1'b1, 32'h80000000, 32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33);

    // Backpressure: result must hold while out_ready stays low.
    exp_q.push_back({1'b0, 32'd3, 32'd0});
    start(1'b0, 32'd9, 32'd3);
    wait_result("bp9_3", 33);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", W'(out_valid), 1);
      chk("bp_in_ready", W'(in_ready), 0);
      chk("bp_quotient", quotient, 32'd3);
      chk("bp_remainder", remainder, 32'd0);
    end
    release_result("bp9_3");
    op("u10_4", 1'b0, 32'd10, 32'd4, 32'd2, 32'd2, 1'b0, 33);

    // Flush at T0+10: back to IDLE, old result registers untouched.
    start(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", W'(in_ready), 1);
    chk("flush_out_valid", W'(out_valid), 0);
    chk("flush_keep_quotient", quotient, 32'd2);
    chk("flush_keep_remainder", remainder, 32'd2);
    watch_quiet("flush_quiet", 40);

    // Reset pulse at T0+20 of another operation.
    start(1'b1, 32'hFFFFFF9C, 32'd3);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_in_ready", W'(in_ready), 1);
    chk("mid_rst_out_valid", W'(out_valid), 0);
    chk("mid_rst_quotient", quotient, 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    watch_quiet("rst_quiet", 40);

    op("u50_5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
